issue_trace_checker: RTL and testbench
======================================

# issue_trace_checker

Synthesizable checker for the issue-stage handshake trace. It consumes an expected sequence of (queueType, pc) records on a valid/ready stream and compares each against the live issue handshake event (`en`, `pc`, `queueType`), in order. Mismatches, missing events and extra events are flagged, with the first failure captured for debug. It sits beside the issue stage and taps the same signals that feed the per-handshake file logger; the expected stream comes from a testbench, trace ROM or DPI source.

## Interface
- `DEPTH`, 16: expected-record FIFO entries; power of two, ≥2
- `PC_W`, 32: pc width
- `QT_W`, 8: queueType width
- `CNT_W`, 32: counter / index width
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `exp_valid` in 1: expected record valid
- `exp_ready` out 1: FIFO accepts record
- `exp_pc` in PC_W, `exp_queueType` in QT_W: expected record
- `exp_last` in 1: record is final of trace
- `en` in 1: live issue handshake this cycle
- `pc` in PC_W, `queueType` in QT_W: live event payload
- `state` out 2: 0 RUN, 1 DONE, 2 FAIL
- `fail_code` out 2: 0 none, 1 mismatch, 2 underflow (event with empty FIFO), 3 overflow (event after DONE)
- `match_count` out CNT_W: events matched
- `err_index` out CNT_W: index of failing event (= match_count at failure)
- `err_exp_pc`, `err_got_pc` out PC_W; `err_exp_qt`, `err_got_qt` out QT_W: first-failure capture

## Operation
- FIFO stores {pc, queueType, last}. Push when `exp_valid && exp_ready`; `exp_ready = !full && state==RUN` (combinational from registered state).
- RUN, `en`=1:
  - FIFO empty → FAIL, code 2; err_got_* ← live, err_exp_* ← 0.
  - Head equal on both fields → pop, match_count+1; if head.last → DONE.
  - Head differs → pop, FAIL, code 1, capture both sides.
- DONE: `en`=1 → FAIL, code 3, capture live into err_got_*. Pushes blocked.
- FAIL: terminal until reset; counters and capture frozen; pushes blocked; `en` ignored.
- No bypass: record pushed in the same cycle as `en` with empty FIFO is not visible; the event is underflow.
- Push and pop in the same cycle permitted when not full and not empty; occupancy unchanged.
- match_count wraps modulo 2^CNT_W; no saturation.
- Compare uses full PC_W and QT_W; no masking.

## Timing
- Reset (sync, active-high, dominates any same-cycle `en` or push): state=RUN, fail_code=0, match_count=0, err_*=0, FIFO empty, so `exp_ready`=1 the following cycle.
- Outputs registered; an `en` in cycle N is reflected in state, counters and capture at N+1.
- `exp_ready` drops the cycle after the FIFO becomes full, or after the state leaves RUN.
- Pointers: log2(DEPTH) bits plus a wrap bit; full and empty are derived from pointer compare. Wrap-around is transparent.
- Reset mid-trace discards FIFO contents and all capture.

## Structure
- Package `issue_trace_pkg`: state encoding (RUN/DONE/FAIL), fail_code constants, packed trace-record typedef {pc, queueType, last}.
- Sub-module `trace_fifo`: synchronous FIFO, parameterized by DEPTH and record width, with push/pop/full/empty. The checker FSM, compare and capture logic stay in the top module.

## Test plan
- Push 3 records (qt=1/pc=0x1000, qt=2/pc=0x1004, qt=1/pc=0x1008 last), then matching `en` events → match_count=3, state=DONE, fail_code=0.
- Push qt=1/pc=0x2000 and qt=1/pc=0x2004; 2nd event pc=0x2008 → FAIL, code 1, err_index=1, err_exp_pc=0x2004, err_got_pc=0x2008.
- `en` with pc=0x3000 and empty FIFO, with a push in the same cycle → FAIL, code 2, err_got_pc=0x3000, match_count=0.
- After DONE, an extra `en` with qt=3/pc=0x4000 → FAIL, code 3, err_got_qt=3.
- Fill 16 records with `exp_valid` held high → `exp_ready`=0 after 16 accepted. Then pop and push simultaneously across 40 matching events (pointer wrap) → match_count=40, no failure.
- Assert `reset` one cycle while in FAIL with `en`=1 → next cycle state=RUN, all outputs 0, `exp_ready`=1.

Source files
------------

// File: rtl/issue_trace_pkg.sv
// -----------------------------------------------------------------------------
// issue_trace_pkg
// Shared definitions for the issue-stage trace checker.
//   - state_e      : checker state encoding (RUN / DONE / FAIL)
//   - FC_*         : fail_code values reported on the fail_code output
//   - trace_rec_t  : canonical expected-trace record {pc, queueType, last} at
//                    the default widths, for trace ROM / DPI sources
// -----------------------------------------------------------------------------
package issue_trace_pkg;

    localparam int TRACE_PC_W = 32;
    localparam int TRACE_QT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_MISMATCH  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_OVERFLOW  = 2'd3;

    typedef struct packed {
        logic [TRACE_PC_W-1:0] pc;
        logic [TRACE_QT_W-1:0] queue_type;
        logic                  last;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding expected trace records. Pointers carry one extra
// wrap bit so full/empty come straight from a pointer compare.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_din   : write request and data (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_dout          : head record (valid when !o_empty)
//   o_full, o_empty : occupancy flags
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 41
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // define which entries are live, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, whatever the block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/issue_trace_checker.sv
// -----------------------------------------------------------------------------
// issue_trace_checker
// Compares live issue handshakes (en, pc, queueType) against an expected
// record stream, in order, and latches the first failure.
// Ports:
//   clk, reset                       : clock, sync active-high reset
//   exp_valid/exp_ready              : expected-record stream handshake
//   exp_pc, exp_queueType, exp_last  : expected record payload
//   en, pc, queueType                : live issue handshake event
//   state                            : 0 RUN, 1 DONE, 2 FAIL
//   fail_code                        : 0 none, 1 mismatch, 2 underflow,
//                                      3 overflow
//   match_count                      : events matched (wraps)
//   err_index, err_exp_*, err_got_*  : first-failure capture
// -----------------------------------------------------------------------------
module issue_trace_checker
    import issue_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 32,
    parameter int QT_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [PC_W-1:0]  exp_pc,
    input  logic [QT_W-1:0]  exp_queueType,
    input  logic             exp_last,
    input  logic             en,
    input  logic [PC_W-1:0]  pc,
    input  logic [QT_W-1:0]  queueType,
    output logic [1:0]       state,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_index,
    output logic [PC_W-1:0]  err_exp_pc,
    output logic [PC_W-1:0]  err_got_pc,
    output logic [QT_W-1:0]  err_exp_qt,
    output logic [QT_W-1:0]  err_got_qt
);

    // Same layout as trace_rec_t, sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [QT_W-1:0] queue_type;
        logic            last;
    } rec_t;

    state_e           r_state;
    logic [1:0]       r_fail_code;
    logic [CNT_W-1:0] r_match_count;
    logic [CNT_W-1:0] r_err_index;
    logic [PC_W-1:0]  r_err_exp_pc;
    logic [PC_W-1:0]  r_err_got_pc;
    logic [QT_W-1:0]  r_err_exp_qt;
    logic [QT_W-1:0]  r_err_got_qt;

    rec_t w_push_rec;
    rec_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_match;

    assign w_push_rec = '{pc: exp_pc, queue_type: exp_queueType, last: exp_last};
    assign exp_ready  = !w_full && (r_state == ST_RUN);
    assign w_push     = exp_valid && exp_ready;
    // Mismatches pop too, but FAIL is terminal so that is harmless.
    assign w_pop      = (r_state == ST_RUN) && en && !w_empty;
    assign w_match    = (w_head.pc == pc) && (w_head.queue_type == queueType);

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(rec_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_push_rec),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_fail_code   <= FC_NONE;
            r_match_count <= '0;
            r_err_index   <= '0;
            r_err_exp_pc  <= '0;
            r_err_got_pc  <= '0;
            r_err_exp_qt  <= '0;
            r_err_got_qt  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (en) begin
                        if (w_empty) begin
                            // Same-cycle push is not visible: no bypass.
                            r_state      <= ST_FAIL;
                            r_fail_code  <= FC_UNDERFLOW;
                            r_err_index  <= r_match_count;
                            r_err_exp_pc <= '0;
                            r_err_exp_qt <= '0;
                            r_err_got_pc <= pc;
                            r_err_got_qt <= queueType;
                        end else if (w_match) begin
                            r_match_count <= r_match_count + CNT_W'(1);
                            if (w_head.last) r_state <= ST_DONE;
                        end else begin
                            r_state      <= ST_FAIL;
                            r_fail_code  <= FC_MISMATCH;
                            r_err_index  <= r_match_count;
                            r_err_exp_pc <= w_head.pc;
                            r_err_exp_qt <= w_head.queue_type;
                            r_err_got_pc <= pc;
                            r_err_got_qt <= queueType;
                        end
                    end
                end
                ST_DONE: begin
                    if (en) begin
                        r_state      <= ST_FAIL;
                        r_fail_code  <= FC_OVERFLOW;
                        r_err_index  <= r_match_count;
                        r_err_exp_pc <= '0;
                        r_err_exp_qt <= '0;
                        r_err_got_pc <= pc;
                        r_err_got_qt <= queueType;
                    end
                end
                ST_FAIL: ;  // terminal until reset
                default: r_state <= ST_FAIL;
            endcase
        end
    end

    assign state       = r_state;
    assign fail_code   = r_fail_code;
    assign match_count = r_match_count;
    assign err_index   = r_err_index;
    assign err_exp_pc  = r_err_exp_pc;
    assign err_got_pc  = r_err_got_pc;
    assign err_exp_qt  = r_err_exp_qt;
    assign err_got_qt  = r_err_got_qt;

endmodule

// File: tb/tb_issue_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_issue_trace_checker
// Directed bench for issue_trace_checker. Inputs change 1ns after a rising
// edge; outputs are sampled at the same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_issue_trace_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [7:0]  exp_queueType;
    logic        exp_last;
    logic        en;
    logic [31:0] pc;
    logic [7:0]  queueType;
    logic [1:0]  state;
    logic [1:0]  fail_code;
    logic [31:0] match_count;
    logic [31:0] err_index;
    logic [31:0] err_exp_pc;
    logic [31:0] err_got_pc;
    logic [7:0]  err_exp_qt;
    logic [7:0]  err_got_qt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_trace_checker #(
        .DEPTH (16),
        .PC_W  (32),
        .QT_W  (8),
        .CNT_W (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .exp_valid     (exp_valid),
        .exp_ready     (exp_ready),
        .exp_pc        (exp_pc),
        .exp_queueType (exp_queueType),
        .exp_last      (exp_last),
        .en            (en),
        .pc            (pc),
        .queueType     (queueType),
        .state         (state),
        .fail_code     (fail_code),
        .match_count   (match_count),
        .err_index     (err_index),
        .err_exp_pc    (err_exp_pc),
        .err_got_pc    (err_got_pc),
        .err_exp_qt    (err_exp_qt),
        .err_got_qt    (err_got_qt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_rec(input logic [7:0] qt, input logic [31:0] p, input logic last);
        exp_valid     = 1'b1;
        exp_queueType = qt;
        exp_pc        = p;
        exp_last      = last;
        tick();
        exp_valid     = 1'b0;
    endtask

    task automatic issue(input logic [7:0] qt, input logic [31:0] p);
        en        = 1'b1;
        queueType = qt;
        pc        = p;
        tick();
        en        = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", fail_code); end
        checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", exp_ready); end
    endtask

    task automatic test_match();
        do_reset();
        push_rec(8'd1, 32'h1000, 1'b0);
        push_rec(8'd2, 32'h1004, 1'b0);
        push_rec(8'd1, 32'h1008, 1'b1);
        issue(8'd1, 32'h1000);
        checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL match_first got %0d want 1", match_count); end
        issue(8'd2, 32'h1004);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL match_mid_state got %0d want 0", state); end
        issue(8'd1, 32'h1008);
        checks++; if (match_count !== 32'd3) begin errors++; $display("FAIL match_count got %0d want 3", match_count); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL match_state got %0d want 1", state); end
        checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL match_code got %0d want 0", fail_code); end
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL done_ready got %0b want 0", exp_ready); end
    endtask

    // Runs straight after test_match, from DONE.
    task automatic test_overflow();
        issue(8'd3, 32'h4000);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ovf_state got %0d want 2", state); end
        checks++; if (fail_code !== 2'd3) begin errors++; $display("FAIL ovf_code got %0d want 3", fail_code); end
        checks++; if (err_got_qt !== 8'd3) begin errors++; $display("FAIL ovf_got_qt got %0d want 3", err_got_qt); end
        checks++; if (err_got_pc !== 32'h4000) begin errors++; $display("FAIL ovf_got_pc got %h want 4000", err_got_pc); end
        checks++; if (err_index !== 32'd3) begin errors++; $display("FAIL ovf_index got %0d want 3", err_index); end
    endtask

    task automatic test_mismatch();
        do_reset();
        push_rec(8'd1, 32'h2000, 1'b0);
        push_rec(8'd1, 32'h2004, 1'b1);
        issue(8'd1, 32'h2000);
        issue(8'd1, 32'h2008);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL mm_state got %0d want 2", state); end
        checks++; if (fail_code !== 2'd1) begin errors++; $display("FAIL mm_code got %0d want 1", fail_code); end
        checks++; if (err_index !== 32'd1) begin errors++; $display("FAIL mm_index got %0d want 1", err_index); end
        checks++; if (err_exp_pc !== 32'h2004) begin errors++; $display("FAIL mm_exp_pc got %h want 2004", err_exp_pc); end
        checks++; if (err_got_pc !== 32'h2008) begin errors++; $display("FAIL mm_got_pc got %h want 2008", err_got_pc); end
        checks++; if (err_exp_qt !== 8'd1) begin errors++; $display("FAIL mm_exp_qt got %0d want 1", err_exp_qt); end
        // FAIL is terminal: further events and pushes change nothing.
        exp_valid = 1'b1;
        issue(8'd1, 32'h9999);
        exp_valid = 1'b0;
        checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL mm_frozen_count got %0d want 1", match_count); end
        checks++; if (err_got_pc !== 32'h2008) begin errors++; $display("FAIL mm_frozen_pc got %h want 2008", err_got_pc); end
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL mm_ready got %0b want 0", exp_ready); end
    endtask

    task automatic test_underflow();
        do_reset();
        exp_valid     = 1'b1;
        exp_queueType = 8'd5;
        exp_pc        = 32'h3000;
        exp_last      = 1'b1;
        issue(8'd5, 32'h3000);
        exp_valid     = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL uf_state got %0d want 2", state); end
        checks++; if (fail_code !== 2'd2) begin errors++; $display("FAIL uf_code got %0d want 2", fail_code); end
        checks++; if (err_got_pc !== 32'h3000) begin errors++; $display("FAIL uf_got_pc got %h want 3000", err_got_pc); end
        checks++; if (err_got_qt !== 8'd5) begin errors++; $display("FAIL uf_got_qt got %0d want 5", err_got_qt); end
        checks++; if (err_exp_pc !== 32'h0) begin errors++; $display("FAIL uf_exp_pc got %h want 0", err_exp_pc); end
        checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL uf_count got %0d want 0", match_count); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int p;
        logic acc_now;
        do_reset();
        // Hold exp_valid high; record index follows the accepted count.
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            exp_valid     = 1'b1;
            exp_pc        = 32'h5000 + 32'(4 * acc);
            exp_queueType = 8'(acc);
            exp_last      = 1'b0;
            acc_now       = exp_ready;
            tick();
            if (acc_now) acc++;
        end
        exp_valid = 1'b0;
        checks++; if (acc !== 16) begin errors++; $display("FAIL fill_accepted got %0d want 16", acc); end
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", exp_ready); end
        // 40 matching events with concurrent refill; pointers wrap past 32.
        p = 16;
        for (int e = 0; e < 40; e++) begin
            en        = 1'b1;
            pc        = 32'h5000 + 32'(4 * e);
            queueType = 8'(e);
            if (p < 40) begin
                exp_valid     = 1'b1;
                exp_pc        = 32'h5000 + 32'(4 * p);
                exp_queueType = 8'(p);
                exp_last      = (p == 39);
            end else begin
                exp_valid = 1'b0;
            end
            acc_now = exp_ready && exp_valid;
            tick();
            if (acc_now) p++;
        end
        en        = 1'b0;
        exp_valid = 1'b0;
        checks++; if (p !== 40) begin errors++; $display("FAIL wrap_pushed got %0d want 40", p); end
        checks++; if (match_count !== 32'd40) begin errors++; $display("FAIL wrap_count got %0d want 40", match_count); end
        checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL wrap_code got %0d want 0", fail_code); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap_state got %0d want 1", state); end
    endtask

    task automatic test_reset_from_fail();
        issue(8'd7, 32'h7000);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset_state got %0d want 2", state); end
        // Reset dominates same-cycle en and push.
        reset         = 1'b1;
        en            = 1'b1;
        pc            = 32'h6000;
        queueType     = 8'd6;
        exp_valid     = 1'b1;
        exp_pc        = 32'h6000;
        exp_queueType = 8'd6;
        exp_last      = 1'b1;
        tick();
        reset     = 1'b0;
        en        = 1'b0;
        exp_valid = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", fail_code); end
        checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", match_count); end
        checks++; if ((err_index | err_exp_pc | err_got_pc) !== 32'd0) begin errors++; $display("FAIL rst_err got %h/%h/%h want 0", err_index, err_exp_pc, err_got_pc); end
        checks++; if ((err_exp_qt | err_got_qt) !== 8'd0) begin errors++; $display("FAIL rst_err_qt got %h/%h want 0", err_exp_qt, err_got_qt); end
        checks++; if (exp_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", exp_ready); end
        // The push during reset must not have landed: this is an underflow.
        issue(8'd6, 32'h6000);
        checks++; if (fail_code !== 2'd2) begin errors++; $display("FAIL rst_fifo_empty got %0d want 2", fail_code); end
    endtask

    initial begin
        reset         = 1'b1;
        exp_valid     = 1'b0;
        exp_pc        = '0;
        exp_queueType = '0;
        exp_last      = 1'b0;
        en            = 1'b0;
        pc            = '0;
        queueType     = '0;
        tick();
        test_reset();
        test_match();
        test_overflow();
        test_mismatch();
        test_underflow();
        test_back_to_back();
        test_reset_from_fail();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
